// File: rtl/ikbd_host_uart.sv
// Host-side 8N1 UART for the IKBD link: oversampled receiver feeding a small FIFO,
// and an independent transmitter driving the MCU SCI receive pin.
module ikbd_host_uart #(
  parameter int BIT_CLKS   = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLKx2,
  input  logic       RST,
  input  logic       RXD,
  output logic       TXD,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_OVR,
  output logic       RX_FERR,
  input  logic       ERR_CLR
);

  localparam int CW   = $clog2(BIT_CLKS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(BIT_CLKS - 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          rx_state;
  logic            rxd_s1, rxd_s2, rxd_q;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sr;
  logic            rx_push, rx_ferr_set;

  // rxd_q holds the previous synchronized level so only a real 1->0 edge starts a frame
  always_ff @(posedge CLKx2 or negedge RST) begin
    if (!RST) begin
      rxd_s1      <= 1'b1;
      rxd_s2      <= 1'b1;
      rxd_q       <= 1'b1;
      rx_state    <= S_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_push     <= 1'b0;
      rx_ferr_set <= 1'b0;
    end else begin
      rxd_s1      <= RXD;
      rxd_s2      <= rxd_s1;
      rxd_q       <= rxd_s2;
      rx_push     <= 1'b0;
      rx_ferr_set <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rxd_q && !rxd_s2) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt      <= '0;
            rx_state    <= S_IDLE;
            rx_push     <= rxd_s2;
            rx_ferr_set <= !rxd_s2;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLKx2) begin
    if (rx_state == S_DATA && rx_cnt == FULL_M1) rx_sr <= {rxd_s2, rx_sr[7:1]};
  end

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_cnt;
  logic            pop, full, wr_en, ovr_set;

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign pop     = (fifo_cnt != '0) && RX_READY;
  assign full    = (fifo_cnt == DEPTH_C);
  assign wr_en   = rx_push && (!full || pop);
  assign ovr_set = rx_push && full && !pop;

  always_ff @(posedge CLKx2 or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      RX_OVR   <= 1'b0;
      RX_FERR  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      RX_OVR  <= (RX_OVR  && !ERR_CLR) || ovr_set;
      RX_FERR <= (RX_FERR && !ERR_CLR) || rx_ferr_set;
    end
  end

  always_ff @(posedge CLKx2) begin
    if (wr_en) mem[wr_ptr] <= rx_sr;
  end

  assign RX_VALID = (fifo_cnt != '0);
  assign RX_DATA  = RX_VALID ? mem[rd_ptr] : 8'h00;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sr;

  assign TX_READY = (tx_state == S_IDLE);

  always_ff @(posedge CLKx2 or negedge RST) begin
    if (!RST) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      TXD      <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (TX_VALID) begin
            tx_state <= S_START;
            tx_cnt   <= '0;
            TXD      <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
            TXD      <= tx_sr[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              TXD      <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              TXD    <= tx_sr[0];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // tx_sr[0] always holds the next data bit to put on the line
  always_ff @(posedge CLKx2) begin
    if (tx_state == S_IDLE && TX_VALID)
      tx_sr <= TX_DATA;
    else if (tx_cnt == FULL_M1 && (tx_state == S_START || tx_state == S_DATA))
      tx_sr <= {1'b0, tx_sr[7:1]};
  end

endmodule

// File: doc/ikbd_host_uart.md
IKBD_HOST_UART -- requirements
Module: ikbd_host_uart

Interface
REQ-001 The block SHALL provide parameter BIT_CLKS, default 256: clock cycles per serial bit; even, >= 8.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two, >= 2.
REQ-003 The block SHALL provide port CLKx2  input  1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port RST  input  1: reset, asynchronous, active-low.
REQ-005 The block SHALL provide port RXD  input  1: serial line driven by the MCU SCI transmitter; asynchronous.
REQ-006 The block SHALL provide port TXD  output  1: serial line driving the MCU SCI receiver input (Port 2 bit 3).
REQ-007 The block SHALL provide port TX_DATA  input  8: byte to transmit.
REQ-008 The block SHALL provide port TX_VALID  input  1: TX_DATA is valid.
REQ-009 The block SHALL provide port TX_READY  output  1: transmitter can accept a byte.
REQ-010 The block SHALL provide port RX_DATA  output  8: receive FIFO head byte.
REQ-011 The block SHALL provide port RX_VALID  output  1: receive FIFO not empty.
REQ-012 The block SHALL provide port RX_READY  input  1: consumer pops the head byte.
REQ-013 The block SHALL provide port RX_OVR  output  1: sticky overrun flag.
REQ-014 The block SHALL provide port RX_FERR  output  1: sticky framing-error flag.
REQ-015 The block SHALL provide port ERR_CLR  input  1: single-cycle clear of RX_OVR and RX_FERR.

Function
REQ-016 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-017 RXD SHALL pass through a two-flop synchronizer; all receive decisions SHALL use the synchronized value.
REQ-018 The receive FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 In IDLE, a synchronized 1->0 transition SHALL enter START with the bit counter cleared; a line that is already low SHALL NOT start a frame.
REQ-020 START SHALL sample the line at counter BIT_CLKS/2-1: a 1 returns to IDLE (glitch, no flag); a 0 clears the counter and enters DATA.
REQ-021 DATA SHALL sample every BIT_CLKS cycles, shift 8 bits LSB first, then enter STOP.
REQ-022 STOP SHALL sample after BIT_CLKS cycles: a 1 pushes the byte into the FIFO; a 0 discards the byte and sets RX_FERR; both outcomes return to IDLE.
REQ-023 A push into a full FIFO SHALL drop the new byte, keep the FIFO contents, and set RX_OVR.
REQ-024 A push into a full FIFO in the same cycle as a pop SHALL succeed with no overrun.
REQ-025 A pop SHALL occur when RX_VALID and RX_READY are both high; RX_READY with an empty FIFO SHALL be ignored.
REQ-026 RX_DATA/RX_VALID SHALL reflect a pushed byte on the cycle after the push; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 ERR_CLR SHALL clear both sticky flags; a flag set in the same cycle as ERR_CLR SHALL remain set.
REQ-028 The transmit FSM SHALL have states IDLE, START, DATA, STOP; TX_READY SHALL be high only in IDLE.
REQ-029 TX_VALID and TX_READY both high SHALL latch TX_DATA; TX_READY SHALL fall and TXD SHALL go 0 on the next cycle.
REQ-030 Each transmitted bit SHALL last exactly BIT_CLKS cycles; TXD SHALL be registered and glitch-free.
REQ-031 TX_READY SHALL return high on the cycle after the stop bit completes, giving 10*BIT_CLKS busy cycles per byte; back-to-back bytes SHALL add no extra idle bits.
REQ-032 Receive and transmit paths SHALL operate fully independently and concurrently.

Reset
REQ-033 While RST is low: TXD=1, TX_READY=1, RX_VALID=0, RX_DATA=0x00, RX_OVR=0, RX_FERR=0, both FSMs in IDLE, FIFO empty, synchronizer flops=1, counters=0.
REQ-034 Reset asserted mid-frame SHALL abort both frames immediately, with no push and no flag set.
REQ-035 After RST deasserts, the first valid start edge SHALL be received normally.

Verification (BIT_CLKS=16, FIFO_DEPTH=4)
REQ-036 RXD frame 0xA5 with a valid stop bit -> RX_VALID rises, RX_DATA=0xA5, flags stay 0.
REQ-037 Five frames 0x01..0x05 with RX_READY=0 -> FIFO holds 0x01..0x04, RX_OVR=1; popping returns 0x01..0x04 in order.
REQ-038 Frame 0x3C with stop bit 0 -> no push, RX_FERR=1; ERR_CLR pulse -> RX_FERR=0.
REQ-039 3-cycle low glitch on RXD -> no push, no flag, receive FSM back in IDLE.
REQ-040 TX_DATA=0x96 accepted -> TXD sequence 0,0,1,1,0,1,0,0,1,1, each bit 16 cycles; TX_READY low for exactly 160 cycles.
REQ-041 RST pulsed low during a TX data bit and an RX data bit -> TXD=1, TX_READY=1, FIFO empty, flags 0.
